// File: rtl/alu_pipe_mc.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | alu_pipe_mc : multi-cycle execute-stage ALU, valid/ready on both sides   |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module alu_pipe_mc #(
  parameter int WIDTH = 64,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             is_less,
  output logic             is_less_s,
  output logic             illegal_op
);

  localparam int CW = SHW + 1;
  localparam logic [CW-1:0] c_one      = CW'(1);
  localparam logic [CW-1:0] c_mul_cnt  = CW'(WIDTH);

  localparam logic [3:0] c_op_and = 4'b0000;
  localparam logic [3:0] c_op_or  = 4'b0001;
  localparam logic [3:0] c_op_add = 4'b0010;
  localparam logic [3:0] c_op_mul = 4'b0011;
  localparam logic [3:0] c_op_sub = 4'b0110;
  localparam logic [3:0] c_op_slt = 4'b0111;
  localparam logic [3:0] c_op_sll = 4'b1000;
  localparam logic [3:0] c_op_srl = 4'b1001;
  localparam logic [3:0] c_op_sra = 4'b1010;
  localparam logic [3:0] c_op_nor = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_is_less;
  logic             r_is_less_s;
  logic             r_illegal;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_count;

  logic [WIDTH-1:0] w_res;
  logic             w_illegal;
  logic             w_is_mul;
  logic             w_accept;
  logic [SHW-1:0]   w_shamt;
  logic             w_lt_s;
  logic [WIDTH-1:0] w_acc_nxt;

  assign w_shamt   = b[SHW-1:0];
  assign w_lt_s    = $signed(a) < $signed(b);
  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

  assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign out_valid = (r_state == S_DONE);
  assign w_accept  = in_valid && in_ready;

  always_comb begin
    w_res     = '0;
    w_illegal = 1'b0;
    w_is_mul  = 1'b0;
    case (alu_op)
      c_op_and: w_res = a & b;
      c_op_or:  w_res = a | b;
      c_op_add: w_res = a + b;
      c_op_sub: w_res = a - b;
      c_op_nor: w_res = ~(a | b);
      c_op_sll: w_res = a << w_shamt;
      c_op_srl: w_res = a >> w_shamt;
      c_op_sra: w_res = $signed(a) >>> w_shamt;
      c_op_slt: w_res = {{(WIDTH-1){1'b0}}, w_lt_s};
      c_op_mul: w_is_mul = 1'b1;
      default:  w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_is_mul ? S_BUSY : S_DONE;
      S_BUSY: if (r_count == c_one) w_state_nxt = S_DONE;
      S_DONE: begin
        if (w_accept)       w_state_nxt = w_is_mul ? S_BUSY : S_DONE;
        else if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Flags are latched at accept so a multiply reports the operands it was issued with.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_is_less   <= 1'b0;
      r_is_less_s <= 1'b0;
      r_illegal   <= 1'b0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_count     <= '0;
    end else if (w_accept) begin
      r_zero      <= (a == b);
      r_is_less   <= (a < b);
      r_is_less_s <= w_lt_s;
      r_illegal   <= w_illegal;
      if (w_is_mul) begin
        r_mcand  <= a;
        r_mplier <= b;
        r_acc    <= '0;
        r_count  <= c_mul_cnt;
      end else begin
        r_result <= w_res;
      end
    end else if (r_state == S_BUSY) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count - c_one;
      if (r_count == c_one) r_result <= w_acc_nxt;
    end
  end

  assign result     = r_result;
  assign zero       = r_zero;
  assign is_less    = r_is_less;
  assign is_less_s  = r_is_less_s;
  assign illegal_op = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe_mc.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_alu_pipe_mc : directed checks of alu_pipe_mc at WIDTH 64, 32 and 16   |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module tb_alu_pipe_mc;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        out_ready = 1'b1;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic [3:0]  alu_op = '0;
  logic        iv64 = 1'b0, iv32 = 1'b0, iv16 = 1'b0;

  logic        ir64, ov64, z64, lt64, lts64, il64;
  logic [63:0] r64;
  logic        ir32, ov32, z32, lt32, lts32, il32;
  logic [31:0] r32;
  logic        ir16, ov16, z16, lt16, lts16, il16;
  logic [15:0] r16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_pipe_mc #(.WIDTH(64)) u_dut64 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv64), .in_ready(ir64),
    .a(a), .b(b), .alu_op(alu_op), .out_valid(ov64), .out_ready(out_ready),
    .result(r64), .zero(z64), .is_less(lt64), .is_less_s(lts64), .illegal_op(il64)
  );

  alu_pipe_mc #(.WIDTH(32)) u_dut32 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv32), .in_ready(ir32),
    .a(a[31:0]), .b(b[31:0]), .alu_op(alu_op), .out_valid(ov32), .out_ready(out_ready),
    .result(r32), .zero(z32), .is_less(lt32), .is_less_s(lts32), .illegal_op(il32)
  );

  alu_pipe_mc #(.WIDTH(16)) u_dut16 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv16), .in_ready(ir16),
    .a(a[15:0]), .b(b[15:0]), .alu_op(alu_op), .out_valid(ov16), .out_ready(out_ready),
    .result(r16), .zero(z16), .is_less(lt16), .is_less_s(lts16), .illegal_op(il16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issues one multiply on the 16-bit instance and tracks the busy window edge by edge.
  task automatic mul16(input logic [15:0] x, input logic [15:0] y, input logic [15:0] exp);
    int bad;
    a      = {48'd0, x};
    b      = {48'd0, y};
    alu_op = 4'b0011;
    check("mul16_in_ready_at_issue", {63'd0, ir16}, 64'd1);
    iv16 = 1'b1;
    @(negedge clk);
    iv16 = 1'b0;
    bad  = 0;
    for (int k = 0; k < 16; k++) begin
      if (ir16 !== 1'b0 || ov16 !== 1'b0) bad++;
      @(negedge clk);
    end
    check("mul16_busy_window", 64'(bad), 64'd0);
    check("mul16_out_valid", {63'd0, ov16}, 64'd1);
    check("mul16_result", {48'd0, r16}, {48'd0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  logic [3:0]  ops2 [5] = '{4'b0000, 4'b0001, 4'b0110, 4'b1100, 4'b1000};
  logic [63:0] exp2 [5] = '{64'h0, 64'hFF, 64'hE1, 64'hFFFF_FFFF_FFFF_FF00, 64'h78_0000};

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_result", r64, 64'd0);
    check("rst_out_valid", {63'd0, ov64}, 64'd0);
    check("rst_flags", {60'd0, z64, lt64, lts64, il64}, 64'd0);
    reset_n = 1'b1;
    #1;
    check("rst_in_ready", {63'd0, ir64}, 64'd1);

    // Test 1: reset in the middle of a multiply
    @(negedge clk);
    a = 64'd7; b = 64'd9; alu_op = 4'b0011; iv64 = 1'b1;
    @(negedge clk);
    iv64 = 1'b0;
    repeat (9) @(negedge clk);
    check("t1_busy_in_ready", {63'd0, ir64}, 64'd0);
    reset_n = 1'b0;
    #1;
    check("t1_rst_out_valid", {63'd0, ov64}, 64'd0);
    check("t1_rst_result", r64, 64'd0);
    check("t1_rst_flags", {60'd0, z64, lt64, lts64, il64}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    a = 64'd3; b = 64'd4; alu_op = 4'b0010; iv64 = 1'b1;
    @(negedge clk);
    iv64 = 1'b0;
    check("t1_add_valid", {63'd0, ov64}, 64'd1);
    check("t1_add_result", r64, 64'd7);
    @(negedge clk);

    // Test 2: back-to-back single-cycle ops
    a = 64'hF0; b = 64'h0F;
    for (int i = 0; i < 5; i++) begin
      alu_op = ops2[i]; iv64 = 1'b1;
      @(negedge clk);
      check($sformatf("t2_result_%0d", i), r64, exp2[i]);
      check($sformatf("t2_flags_%0d", i), {61'd0, ov64, z64, lt64}, 64'b100);
    end
    iv64 = 1'b0;
    @(negedge clk);

    // Test 3: shifts and signed compare at WIDTH 32
    a = 64'h8000_0000; b = 64'h21; alu_op = 4'b1001; iv32 = 1'b1;
    @(negedge clk);
    check("t3_srl", {32'd0, r32}, 64'h4000_0000);
    alu_op = 4'b1010;
    @(negedge clk);
    check("t3_sra", {32'd0, r32}, 64'hC000_0000);
    b = 64'd1; alu_op = 4'b0111;
    @(negedge clk);
    iv32 = 1'b0;
    check("t3_slt_result", {32'd0, r32}, 64'd1);
    check("t3_slt_is_less", {63'd0, lt32}, 64'd0);
    check("t3_slt_is_less_s", {63'd0, lts32}, 64'd1);
    @(negedge clk);

    // Test 4: multiply at WIDTH 16, second issue straight from DONE
    mul16(16'h1234, 16'h0005, 16'h5B04);
    mul16(16'hFFFF, 16'hFFFF, 16'h0001);
    @(negedge clk);

    // Test 5: backpressure holds result and flags
    out_ready = 1'b0;
    a = 64'd10; b = 64'd20; alu_op = 4'b0010; iv64 = 1'b1;
    @(negedge clk);
    iv64 = 1'b0;
    a = 64'd99; b = 64'd99;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t5_hold_result_%0d", i), r64, 64'd30);
      check($sformatf("t5_hold_ctl_%0d", i), {59'd0, ov64, ir64, z64, lt64, lts64}, 64'b10011);
      @(negedge clk);
    end
    out_ready = 1'b1;
    a = 64'd50; b = 64'd8; alu_op = 4'b0110; iv64 = 1'b1;
    #1;
    check("t5_in_ready_release", {63'd0, ir64}, 64'd1);
    @(negedge clk);
    iv64 = 1'b0;
    check("t5_next_result", r64, 64'd42);
    check("t5_next_valid", {63'd0, ov64}, 64'd1);

    // Test 6: undefined opcode, then a legal one
    a = 64'd5; b = 64'd5; alu_op = 4'b1111; iv64 = 1'b1;
    @(negedge clk);
    check("t6_illegal_result", r64, 64'd0);
    check("t6_illegal_flags", {62'd0, il64, z64}, 64'b11);
    b = 64'd3; alu_op = 4'b0000;
    @(negedge clk);
    iv64 = 1'b0;
    check("t6_legal_result", r64, 64'd1);
    check("t6_legal_illegal_op", {63'd0, il64}, 64'd0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
